// File: rtl/hazard_ctrl_if.sv
// Hazard controller bus: ID-stage instruction info in, forwarding selects and pipeline holds out.
interface hazard_ctrl_if #(
  parameter int unsigned REG_ADDR_W = 5
);
  logic                  id_valid;
  logic [REG_ADDR_W-1:0] id_rs;
  logic [REG_ADDR_W-1:0] id_rt;
  logic                  id_use_rs;
  logic                  id_use_rt;
  logic [REG_ADDR_W-1:0] id_rd;
  logic                  id_regwrite;
  logic                  id_memread;
  logic                  id_mdu;
  logic                  flush;
  logic [1:0]            fwd_a;
  logic [1:0]            fwd_b;
  logic                  stall;
  logic                  mdu_busy;

  modport master (
    output id_valid, id_rs, id_rt, id_use_rs, id_use_rt, id_rd,
           id_regwrite, id_memread, id_mdu, flush,
    input  fwd_a, fwd_b, stall, mdu_busy
  );

  modport slave (
    input  id_valid, id_rs, id_rt, id_use_rs, id_use_rt, id_rd,
           id_regwrite, id_memread, id_mdu, flush,
    output fwd_a, fwd_b, stall, mdu_busy
  );
endinterface

// File: rtl/hazard_ctrl.sv
// Stateful hazard/forwarding controller with shadow EX/MEM/WB tag pipeline.
// Define HAZARD_MDU_EN to enable multi-cycle MDU tracking (counter + mdu_busy).
module hazard_ctrl #(
  parameter int unsigned REG_ADDR_W = 5,
  parameter int unsigned MDU_LAT    = 4
) (
  input  logic         clk,
  input  logic         reset,
  hazard_ctrl_if.slave bus
);

  typedef logic [REG_ADDR_W-1:0] reg_t;

  typedef struct packed {
    logic v;
    reg_t rs;
    reg_t rt;
    logic use_rs;
    logic use_rt;
    reg_t rd;
    logic rw;
    logic mr;
    logic mdu;
  } ex_t;

  typedef struct packed {
    logic v;
    reg_t rd;
    logic rw;
  } st_t;

  ex_t  r_ex;
  st_t  r_mem;
  st_t  r_wb;
  ex_t  w_id;
  logic w_load_use;
  logic w_mdu_busy;
  logic w_stall;
  logic w_accept;
  logic w_unused;

  function automatic logic writes(input st_t s);
    return s.v & s.rw & (s.rd != '0);
  endfunction

  function automatic logic [1:0] fwd_sel(input logic rd_en, input reg_t src,
                                         input st_t mem, input st_t wb);
    if (rd_en && writes(mem) && mem.rd == src)     return 2'b10;
    else if (rd_en && writes(wb) && wb.rd == src)  return 2'b01;
    else                                           return 2'b00;
  endfunction

  always_comb begin
    w_id        = '0;
    w_id.v      = 1'b1;
    w_id.rs     = bus.id_rs;
    w_id.rt     = bus.id_rt;
    w_id.use_rs = bus.id_use_rs;
    w_id.use_rt = bus.id_use_rt;
    w_id.rd     = bus.id_rd;
    w_id.rw     = bus.id_regwrite;
    w_id.mr     = bus.id_memread;
    w_id.mdu    = bus.id_mdu;
  end

  always_comb begin
    w_load_use = r_ex.v & r_ex.mr & (r_ex.rd != '0) & bus.id_valid &
                 ((bus.id_use_rs & (bus.id_rs == r_ex.rd)) |
                  (bus.id_use_rt & (bus.id_rt == r_ex.rd)));
    w_stall    = w_load_use | w_mdu_busy;
    w_accept   = bus.id_valid & ~w_stall & ~bus.flush;
  end

  assign bus.fwd_a    = fwd_sel(r_ex.v & r_ex.use_rs, r_ex.rs, r_mem, r_wb);
  assign bus.fwd_b    = fwd_sel(r_ex.v & r_ex.use_rt, r_ex.rt, r_mem, r_wb);
  assign bus.stall    = w_stall;
  assign bus.mdu_busy = w_mdu_busy;

  // While the MDU holds EX, WB keeps draining and MEM is fed bubbles.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ex  <= '0;
      r_mem <= '0;
      r_wb  <= '0;
    end else begin
      r_wb <= r_mem;
      if (w_mdu_busy) begin
        r_mem <= '0;
      end else begin
        r_mem <= '{v: r_ex.v, rd: r_ex.rd, rw: r_ex.rw};
        r_ex  <= w_accept ? w_id : '0;
      end
    end
  end

`ifdef HAZARD_MDU_EN
  localparam int unsigned CW = $clog2(MDU_LAT) + 1;

  logic [CW-1:0] r_cnt;

  assign w_mdu_busy = (r_cnt != '0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (w_mdu_busy) begin
      r_cnt <= r_cnt - 1'b1;
    end else if (w_accept & bus.id_mdu) begin
      r_cnt <= CW'(MDU_LAT - 1);
    end
  end

  assign w_unused = r_ex.mdu;
`else
  assign w_mdu_busy = 1'b0;
  assign w_unused   = r_ex.mdu | bus.id_mdu | (MDU_LAT == 0);
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed scoreboard bench for hazard_ctrl; expectations adapt to HAZARD_MDU_EN.
module tb_hazard_ctrl;

`ifdef HAZARD_MDU_EN
  localparam logic MDU_ON = 1'b1;
`else
  localparam logic MDU_ON = 1'b0;
`endif

  typedef struct {
    string      tag;
    logic [1:0] fa;
    logic [1:0] fb;
    logic       st;
    logic       mb;
  } exp_t;

  logic clk;
  logic reset;
  int   total;
  int   bad;
  exp_t q[$];

  hazard_ctrl_if #(.REG_ADDR_W(5)) bus ();

  hazard_ctrl #(.REG_ADDR_W(5), .MDU_LAT(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic drive(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                       input logic urs, input logic urt, input logic [4:0] rd,
                       input logic rw, input logic mr, input logic mdu, input logic fl);
    bus.id_valid    = v;
    bus.id_rs       = rs;
    bus.id_rt       = rt;
    bus.id_use_rs   = urs;
    bus.id_use_rt   = urt;
    bus.id_rd       = rd;
    bus.id_regwrite = rw;
    bus.id_memread  = mr;
    bus.id_mdu      = mdu;
    bus.flush       = fl;
  endtask

  task automatic idle();
    drive(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic expect_out(input string tag, input logic [1:0] fa, input logic [1:0] fb,
                            input logic st, input logic mb);
    exp_t e;
    e.tag = tag; e.fa = fa; e.fb = fb; e.st = st; e.mb = mb;
    q.push_back(e);
  endtask

  task automatic check();
    exp_t e;
    while (q.size() > 0) begin
      e = q.pop_front();
      total++;
      assert (bus.fwd_a === e.fa) else begin
        bad++; $error("FAIL %s fwd_a got=%b exp=%b", e.tag, bus.fwd_a, e.fa);
      end
      total++;
      assert (bus.fwd_b === e.fb) else begin
        bad++; $error("FAIL %s fwd_b got=%b exp=%b", e.tag, bus.fwd_b, e.fb);
      end
      total++;
      assert (bus.stall === e.st) else begin
        bad++; $error("FAIL %s stall got=%b exp=%b", e.tag, bus.stall, e.st);
      end
      total++;
      assert (bus.mdu_busy === e.mb) else begin
        bad++; $error("FAIL %s mdu_busy got=%b exp=%b", e.tag, bus.mdu_busy, e.mb);
      end
    end
  endtask

  // Outputs are sampled on the falling edge; inputs change 1 time unit after the rising edge.
  task automatic step(input string tag, input logic [1:0] fa, input logic [1:0] fb,
                      input logic st, input logic mb);
    expect_out(tag, fa, fb, st, mb);
    @(negedge clk);
    check();
    @(posedge clk);
    #1;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    reset = 1'b1;
    idle();
    repeat (2) @(posedge clk);
    expect_out("reset", 2'b00, 2'b00, 1'b0, 1'b0);
    @(negedge clk);
    check();
    @(posedge clk);
    #1;
    reset = 1'b0;

    // add $3,$1,$2 ; sub $4,$3,$5
    drive(1, 5'd1, 5'd2, 1, 1, 5'd3, 1, 0, 0, 0); step("add3",     2'b00, 2'b00, 0, 0);
    drive(1, 5'd3, 5'd5, 1, 1, 5'd4, 1, 0, 0, 0); step("sub_id",   2'b00, 2'b00, 0, 0);
    idle();                                       step("sub_ex",   2'b10, 2'b00, 0, 0);

    // $3 in both MEM and WB, used by EX: MEM wins
    drive(1, 5'd1, 5'd1, 1, 1, 5'd3, 1, 0, 0, 0); step("a1",       2'b00, 2'b00, 0, 0);
    drive(1, 5'd2, 5'd2, 1, 1, 5'd3, 1, 0, 0, 0); step("a2",       2'b00, 2'b00, 0, 0);
    drive(1, 5'd3, 5'd3, 1, 1, 5'd6, 1, 0, 0, 0); step("or_id",    2'b00, 2'b00, 0, 0);
    idle();                                       step("memwins",  2'b10, 2'b10, 0, 0);

    // $0 written in MEM and WB, used by EX: never forwarded
    drive(1, 5'd1, 5'd1, 1, 1, 5'd0, 1, 0, 0, 0); step("z1",       2'b00, 2'b00, 0, 0);
    drive(1, 5'd1, 5'd1, 1, 1, 5'd0, 1, 0, 0, 0); step("z2",       2'b00, 2'b00, 0, 0);
    drive(1, 5'd0, 5'd0, 1, 1, 5'd7, 1, 0, 0, 0); step("use0_id",  2'b00, 2'b00, 0, 0);
    idle();                                       step("rd0",      2'b00, 2'b00, 0, 0);

    // lw $8 ; add $9,$8,$1 -> one stall, then WB forward
    drive(1, 5'd1, 5'd0, 1, 0, 5'd8, 1, 1, 0, 0); step("lw8",      2'b00, 2'b00, 0, 0);
    drive(1, 5'd8, 5'd1, 1, 1, 5'd9, 1, 0, 0, 0); step("lu_stall", 2'b00, 2'b00, 1, 0);
    drive(1, 5'd8, 5'd1, 1, 1, 5'd9, 1, 0, 0, 0); step("lu_retry", 2'b00, 2'b00, 0, 0);
    idle();                                       step("lu_fwd",   2'b01, 2'b00, 0, 0);

    // flushed add $10 must not be forwarded to add $11,$10,$10
    drive(1, 5'd1, 5'd2, 1, 1, 5'd10, 1, 0, 0, 1); step("flush",    2'b00, 2'b00, 0, 0);
    drive(1, 5'd10, 5'd10, 1, 1, 5'd11, 1, 0, 0, 0); step("post_fl", 2'b00, 2'b00, 0, 0);
    idle();                                       step("fl_nofwd", 2'b00, 2'b00, 0, 0);

    // flush together with load-use: stall still reported
    drive(1, 5'd1, 5'd0, 1, 0, 5'd12, 1, 1, 0, 0); step("lw12",     2'b00, 2'b00, 0, 0);
    drive(1, 5'd12, 5'd12, 1, 1, 5'd13, 1, 0, 0, 1); step("fl_lu",  2'b00, 2'b00, 1, 0);
    idle();                                       step("fl_lu_aft", 2'b00, 2'b00, 0, 0);

    // add $16 ; mult $14,$16,$16 ; add $15,$14,$1
    drive(1, 5'd1, 5'd2, 1, 1, 5'd16, 1, 0, 0, 0); step("a16",      2'b00, 2'b00, 0, 0);
    drive(1, 5'd16, 5'd16, 1, 1, 5'd14, 1, 0, 1, 0); step("mul_id", 2'b00, 2'b00, 0, 0);
    drive(1, 5'd14, 5'd1, 1, 1, 5'd15, 1, 0, 0, 0);
`ifdef HAZARD_MDU_EN
    step("mdu_b1", 2'b10, 2'b10, 1, 1);
    step("mdu_b2", 2'b01, 2'b01, 1, 1);
    step("mdu_b3", 2'b00, 2'b00, 1, 1);
    step("mdu_end", 2'b00, 2'b00, 0, 0);
    idle();
    step("mdu_fwd", 2'b10, 2'b00, 0, 0);
`else
    step("nomdu_1", 2'b10, 2'b10, 0, 0);
    idle();
    step("nomdu_fwd", 2'b10, 2'b00, 0, 0);
`endif

    // asynchronous reset in the middle of an MDU op
    drive(1, 5'd1, 5'd2, 1, 1, 5'd17, 1, 0, 1, 0); step("mul17",   2'b00, 2'b00, 0, 0);
    idle();                                        step("mul17_b", 2'b00, 2'b00, MDU_ON, MDU_ON);
    @(negedge clk);
    #2;
    reset = 1'b1;
    #1;
    expect_out("rst_async", 2'b00, 2'b00, 1'b0, 1'b0);
    check();
    @(posedge clk);
    #1;
    reset = 1'b0;

    // fresh count after reset
    drive(1, 5'd3, 5'd3, 1, 1, 5'd18, 1, 0, 1, 0); step("mul18",   2'b00, 2'b00, 0, 0);
    idle();
    step("m18_b1", 2'b00, 2'b00, MDU_ON, MDU_ON);
    step("m18_b2", 2'b00, 2'b00, MDU_ON, MDU_ON);
    step("m18_b3", 2'b00, 2'b00, MDU_ON, MDU_ON);
    step("m18_end", 2'b00, 2'b00, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
